shift_req_stage: RTL and testbench
==================================

Name: shift_req_stage

Overview:
- Request-issue stage directly upstream of the 32-bit combinational barrel shifter.
- Accepts shift requests (opcode, operand, 6-bit amount) over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each request into the shifter's drive signals (data, 5-bit control, direction, arithmetic) and presents them with a valid/ready handshake to the consumer that samples the shifter output.
- Resolves out-of-range amounts (>=32) itself, so the shifter only ever sees amounts 0..31, and rejects illegal opcodes.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, >=2.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_op  input  2  00=SLL, 01=SRL, 11=SRA, 10=illegal.
- in_data  input  32  operand.
- in_amt  input  6  shift amount 0..63.
- out_valid  output  1  head entry valid on sh_* this cycle.
- out_ready  input  1  consumer samples shifter result this cycle.
- sh_in  output  32  operand to shifter.
- sh_ctrl  output  5  shift amount to shifter.
- sh_dir  output  1  1=right, 0=left.
- sh_arith  output  1  1=sign fill on right shift.
- err_illegal  output  1  one-cycle pulse when an illegal request is accepted.
- illegal_cnt  output  CNT_W  saturating count of illegal requests.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; write/read pointers and count = 0.
  - out_valid=0, in_ready=1 (after reset), err_illegal=0, illegal_cnt=0.
  - sh_* = 0.
- Accept: in_valid && in_ready on a rising edge.
- in_ready = (count < DEPTH) and is registered-state only; it has no combinational path from out_ready or in_valid.
- Pop: out_valid && out_ready on a rising edge.
- Handshake rules:
  - out_valid = (count != 0).
  - sh_* are driven from the head entry and forced to 0 when empty.
  - sh_* hold stable while out_valid && !out_ready.
- Latency: a request accepted in cycle N appears on sh_*/out_valid in cycle N+1 (registered FIFO, no bypass).
- Decode (done at accept, stored per entry as {sh_in, sh_ctrl, sh_dir, sh_arith}):
  - SLL: dir=0, arith=0.
  - SRL: dir=1, arith=0.
  - SRA: dir=1, arith=1.
  - amt<32: sh_in=in_data, sh_ctrl=in_amt[4:0].
  - amt>=32, SLL/SRL: sh_in=0, sh_ctrl=0 (result 0).
  - amt>=32, SRA: sh_in={32{in_data[31]}}, sh_ctrl=0 (result all sign bits).
- Illegal op (10):
  - Still consumes the handshake (accepted only when in_ready=1) but is not enqueued.
  - err_illegal=1 for exactly the following cycle.
  - illegal_cnt increments, saturating at all-ones.
- Simultaneous push and pop:
  - Legal when 0<count<DEPTH; count unchanged, pointers both advance.
  - When full, in_ready=0 so no push, even if a pop occurs the same cycle; in_ready rises the cycle after the pop.
- Empty with push: count 0 to 1; out_valid rises next cycle.
- Pointers wrap modulo DEPTH; count is a separate register of width clog2(DEPTH)+1.
- Reset mid-operation: all buffered entries are discarded immediately; no partial output.
- in_* are ignored when !in_valid; X on in_* with in_valid=0 must not propagate.

Decomposition:
- Shared package shift_pkg:
  - Opcode constants OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_ILL=2'b10.
  - Entry typedef shift_req_t {data[31:0], ctrl[4:0], dir, arith}.
  - Constant SHIFT_W=32.
- One natural sub-module: shift_req_fifo (generic DEPTH-entry valid/ready FIFO of shift_req_t, registered outputs, count-based full/empty).
- Decode stays inline in shift_req_stage.

Test Plan:
- Reset then SRA in_data=32'hD011E019, amt=4 -> next cycle out_valid=1, sh_in=32'hD011E019, sh_ctrl=4, sh_dir=1, sh_arith=1.
- SLL amt=40, in_data=32'hFFFFFFFF -> sh_in=0, sh_ctrl=0, sh_dir=0. SRA amt=63, in_data=32'h80000000 -> sh_in=32'hFFFFFFFF, sh_ctrl=0.
- out_ready=0; push 3 back-to-back SRL requests (amt 1, 2, 3) -> first two accepted, in_ready=0 from the cycle after the 2nd accept; sh_ctrl holds at 1. Raise out_ready -> pops in order 1, 2, 3, with the 3rd accepted the cycle after the first pop.
- Continuous in_valid and out_ready=1 with count=1 -> one accept and one pop per cycle, count stays 1, order preserved across pointer wrap (8 requests).
- in_op=10 accepted -> err_illegal pulses 1 cycle, illegal_cnt 0 to 1, out_valid stays 0. 300 illegal requests -> illegal_cnt saturates at 255.
- Fill FIFO, assert rst_n=0 mid-cycle -> out_valid, sh_*, illegal_cnt drop to 0 immediately (asynchronously); in_ready=1 after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift request stage and its FIFO.
// The request entry holds fully decoded shifter drive signals.
package shift_pkg;

    localparam int SHIFT_W = 32;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;
    localparam logic [1:0] OP_ILL = 2'b10;

    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic [4:0]         ctrl;
        logic               dir;
        logic               arith;
    } shift_req_t;

endpackage

// File: rtl/shift_req_fifo.sv
// DEPTH-entry FIFO of decoded shift requests with count-based full/empty.
// Head entry is read straight from storage and forced to zero when empty.
module shift_req_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  shift_req_t din_i,
    input  logic       pop_i,
    output shift_req_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    shift_req_t          mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

    // Head entry, zeroed while empty so stale data never reaches the shifter.
    always_comb begin
        dout_o = '0;
        if (empty_o) begin
            dout_o = '0;
        end else begin
            dout_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/shift_req_stage.sv
// Request-issue stage ahead of the 32-bit barrel shifter: decodes, buffers and
// issues shift requests, folding amounts >= 32 and rejecting illegal opcodes.
module shift_req_stage
    import shift_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [SHIFT_W-1:0] in_data,
    input  logic [5:0]         in_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] sh_in,
    output logic [4:0]         sh_ctrl,
    output logic               sh_dir,
    output logic               sh_arith,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    shift_req_t       dec_req;
    shift_req_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             acc_illegal;
    logic             acc_legal;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ready    = !fifo_full;
    assign accept      = in_valid && in_ready;
    assign acc_illegal = accept && (in_op == OP_ILL);
    assign acc_legal   = accept && (in_op != OP_ILL);

    // Decode to shifter drive; out-of-range amounts become a zero-amount shift
    // of the already-final result (0 or replicated sign bit).
    always_comb begin
        dec_req = '0;
        case (in_op)
            OP_SLL:  begin dec_req.dir = 1'b0; dec_req.arith = 1'b0; end
            OP_SRL:  begin dec_req.dir = 1'b1; dec_req.arith = 1'b0; end
            OP_SRA:  begin dec_req.dir = 1'b1; dec_req.arith = 1'b1; end
            default: begin dec_req.dir = 1'b0; dec_req.arith = 1'b0; end
        endcase
        if (in_amt[5] == 1'b0) begin
            dec_req.data = in_data;
            dec_req.ctrl = in_amt[4:0];
        end else if (in_op == OP_SRA) begin
            dec_req.data = {SHIFT_W{in_data[SHIFT_W-1]}};
            dec_req.ctrl = 5'd0;
        end else begin
            dec_req.data = {SHIFT_W{1'b0}};
            dec_req.ctrl = 5'd0;
        end
    end

    shift_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (acc_legal),
        .din_i   (dec_req),
        .pop_i   (out_ready),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign sh_in     = head.data;
    assign sh_ctrl   = head.ctrl;
    assign sh_dir    = head.dir;
    assign sh_arith  = head.arith;

    // Illegal-request pulse and saturating counter next-state.
    always_comb begin
        err_d = acc_illegal;
        cnt_d = cnt_q;
        if (acc_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Illegal-request status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_illegal = err_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_shift_req_stage.sv
// Directed bench for shift_req_stage: decode, back-pressure, streaming wrap,
// illegal-opcode handling and asynchronous reset, with hand-computed values.
module tb_shift_req_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [5:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_in;
    logic [4:0]  sh_ctrl;
    logic        sh_dir;
    logic        sh_arith;
    logic        err_illegal;
    logic [7:0]  illegal_cnt;

    int n_tests;
    int n_fail;

    shift_req_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_data     (in_data),
        .in_amt      (in_amt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sh_in       (sh_in),
        .sh_ctrl     (sh_ctrl),
        .sh_dir      (sh_dir),
        .sh_arith    (sh_arith),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [5:0] a);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sh_in", sh_in, 32'h0);
        chk("rst_sh_ctrl", 32'(sh_ctrl), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // SRA amt 4
        drive(1'b1, 2'b11, 32'hD011E019, 6'd4);
        step();
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        chk("sra_valid", 32'(out_valid), 32'd1);
        chk("sra_sh_in", sh_in, 32'hD011E019);
        chk("sra_ctrl", 32'(sh_ctrl), 32'd4);
        chk("sra_dir", 32'(sh_dir), 32'd1);
        chk("sra_arith", 32'(sh_arith), 32'd1);
        out_ready = 1'b1;
        step();
        chk("sra_popped", 32'(out_valid), 32'd0);
        chk("empty_sh_in", sh_in, 32'h0);
        out_ready = 1'b0;

        // SLL amt 40 folds to zero
        drive(1'b1, 2'b00, 32'hFFFFFFFF, 6'd40);
        step();
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        chk("sll40_valid", 32'(out_valid), 32'd1);
        chk("sll40_sh_in", sh_in, 32'h0);
        chk("sll40_ctrl", 32'(sh_ctrl), 32'd0);
        chk("sll40_dir", 32'(sh_dir), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // SRA amt 63 folds to sign fill
        drive(1'b1, 2'b11, 32'h80000000, 6'd63);
        step();
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        chk("sra63_sh_in", sh_in, 32'hFFFFFFFF);
        chk("sra63_ctrl", 32'(sh_ctrl), 32'd0);
        chk("sra63_dir", 32'(sh_dir), 32'd1);
        out_ready = 1'b1;
        step();
        chk("sra63_popped", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Back-pressure: three SRL requests into a 2-deep FIFO
        drive(1'b1, 2'b01, 32'h00000011, 6'd1);
        step();
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        drive(1'b1, 2'b01, 32'h00000022, 6'd2);
        step();
        chk("bp_ready_after2", 32'(in_ready), 32'd0);
        chk("bp_hold1", 32'(sh_ctrl), 32'd1);
        drive(1'b1, 2'b01, 32'h00000033, 6'd3);
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold1b", 32'(sh_ctrl), 32'd1);
        chk("bp_hold_data", sh_in, 32'h00000011);
        out_ready = 1'b1;
        step();
        chk("bp_pop2_ctrl", 32'(sh_ctrl), 32'd2);
        chk("bp_ready_rise", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        chk("bp_pop3_ctrl", 32'(sh_ctrl), 32'd3);
        chk("bp_pop3_data", sh_in, 32'h00000033);
        chk("bp_pop3_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming with count held at 1 across pointer wraps
        drive(1'b1, 2'b00, 32'h0, 6'd0);
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 2'b00, 32'(k * 3), 6'(k));
            step();
            chk("stream_ctrl", 32'(sh_ctrl), 32'(k));
            chk("stream_data", sh_in, 32'(k * 3));
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        step();
        chk("stream_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Illegal opcode
        drive(1'b1, 2'b10, 32'h12345678, 6'd5);
        step();
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
        chk("ill_no_enq", 32'(out_valid), 32'd0);
        in_op   = 2'bxx;
        in_data = 32'hxxxxxxxx;
        in_amt  = 6'bxxxxxx;
        step();
        chk("ill_err_drop", 32'(err_illegal), 32'd0);
        chk("x_idle_valid", 32'(out_valid), 32'd0);
        chk("x_idle_cnt", 32'(illegal_cnt), 32'd1);
        drive(1'b1, 2'b10, 32'h0, 6'd0);
        repeat (300) step();
        chk("ill_sat", 32'(illegal_cnt), 32'd255);
        chk("ill_err_stream", 32'(err_illegal), 32'd1);
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        step();

        // Fill, then asynchronous reset mid-cycle
        drive(1'b1, 2'b01, 32'hCAFEF00D, 6'd7);
        step();
        drive(1'b1, 2'b01, 32'h0BADBEEF, 6'd9);
        step();
        drive(1'b0, 2'b00, 32'h0, 6'd0);
        chk("fill_full", 32'(in_ready), 32'd0);
        chk("fill_head", sh_in, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_sh_in", sh_in, 32'h0);
        chk("arst_ctrl", 32'(sh_ctrl), 32'd0);
        chk("arst_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
